ifetch_align: RTL and testbench
===============================

# ifetch_align

Instruction fetch/realign unit that consumes the PC stream produced by the next-PC logic and returns decodable instructions. It issues word-aligned read requests to instruction memory, buffers returned halfwords, realigns 16-bit (RVC) and 32-bit instructions, including 32-bit instructions that straddle a word boundary, and presents one instruction at a time, with its PC and compressed flag, to decode. On a redirect (jump), it flushes its buffer and discards stale in-flight responses.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch/PC value after reset.
- `BUF_HW`, default 6: halfword buffer depth; must be even and at least 4.
- `MAX_OUT`, default 2: maximum outstanding memory requests, stale plus live.

Ports:
- `clk`  in  1: clock; all state on rising edge.
- `rstn`  in  1: asynchronous, active-low reset.
- `redirect_en`  in  1: jump taken this cycle.
- `redirect_addr`  in  32: jump target; bit 0 ignored.
- `imem_req_valid`  out  1: read request valid.
- `imem_req_addr`  out  32: word-aligned request address, [1:0]=00.
- `imem_req_ready`  in  1: memory accepts request.
- `imem_rsp_valid`  in  1: read data valid; in order, never back-pressured.
- `imem_rsp_data`  in  32: read word, low halfword at lower address.
- `ins_valid`  out  1: instruction available to decode.
- `ins_ready`  in  1: decode accepts instruction.
- `ins_data`  out  32: instruction; RVC is zero-extended in [15:0].
- `ins_pc`  out  32: PC of `ins_data`.
- `ins_c`  out  1: 1 when the instruction is compressed (`ins_data[1:0]`≠11).

## Operation
- **State**
  - `fetch_addr`: next word address.
  - `pc`: head PC.
  - Halfword FIFO `buf` with count 0..`BUF_HW`.
  - `live_cnt`: outstanding requests whose data will be kept.
  - `stale_cnt`: outstanding requests whose data will be dropped.
  - `drop_hw`: discard low halfword of next live response.
- **Request**
  - `imem_req_valid` = !`redirect_en` && (`live_cnt`+`stale_cnt`<`MAX_OUT`) && (`BUF_HW`−count−2·`live_cnt` ≥ 2).
  - On handshake: `live_cnt`++ and `fetch_addr`+=4.
- **Response**
  - If `stale_cnt`>0: drop the response and decrement `stale_cnt`.
  - Otherwise: push both halfwords (or only the high halfword if `drop_hw`, then clear `drop_hw`) and decrement `live_cnt`.
- **Output**
  - Head halfword `hw0`, next halfword `hw1`.
  - Compressed when `hw0[1:0]`≠11: `ins_valid` = count≥1, `ins_data`={16'h0,`hw0`}.
  - Otherwise: `ins_valid` = count≥2, `ins_data`={`hw1`,`hw0`}.
  - `ins_pc`=`pc`. All outputs are combinational from registered state only.
  - On `ins_valid`&&`ins_ready`: pop 1 (RVC) or 2 halfwords; `pc`+=2 or +4 (32-bit wrap).
- **Redirect** (highest priority over pop, push and request in the same cycle)
  - Clear buffer.
  - `pc`←{`redirect_addr`[31:1],0}.
  - `fetch_addr`←{`redirect_addr`[31:2],00}.
  - `drop_hw`←`redirect_addr`[1].
  - `stale_cnt`←`stale_cnt`+`live_cnt`−(`imem_rsp_valid`?1:0); any response arriving in the redirect cycle is discarded.
  - `live_cnt`←0.
- **Reset**
  - `pc`=`fetch_addr`=`RESET_PC` (word-aligned; `drop_hw`=`RESET_PC`[1]).
  - Buffer empty; `live_cnt`=`stale_cnt`=0.
  - Outputs: `ins_valid`=0, `ins_c`=0, `ins_pc`=`RESET_PC`, `ins_data`=0, `imem_req_valid`=1, `imem_req_addr`=`RESET_PC`&~3.
  - Assertion of `rstn` mid-operation abandons all in-flight requests; memory must also be reset.

## Timing
- First request in the first cycle after reset release.
- With 1-cycle memory: response in cycle N+1, `ins_valid` in cycle N+2.
- A straddling 32-bit instruction becomes valid only after the second word arrives.
- Redirect in cycle R:
  - No request in R.
  - Request to the target word in R+1.
  - Earliest `ins_valid` in R+3 (1-cycle memory, no stale responses blocking the `MAX_OUT` limit).
- `ins_*` hold stable while `ins_valid`&&!`ins_ready`, unless `redirect_en`, which drops `ins_valid` next cycle.
- Buffer never overflows: push capacity is reserved at request time.

## Configuration
- `IFETCH_RVC_EN` defined: RVC realignment as described.
- Undefined:
  - `ins_c` tied 0.
  - Every instruction pops 2 halfwords; `pc`+=4.
  - `redirect_addr`[1:0] and `RESET_PC`[1:0] are ignored (forced 00); `drop_hw` logic is removed.

## Test plan
- **Reset, 32-bit fetch.** `RESET_PC`=0, mem[0]=0x00000013, 1-cycle memory, `ins_ready`=1 → `ins_valid` at cycle 2 with `ins_pc`=0, `ins_data`=0x00000013, `ins_c`=0; next `ins_pc`=4.
- **Two RVC in one word.** mem[0]=0x45010505 → `ins_data` 0x00000505 @pc 0, then 0x00004501 @pc 2, `ins_c`=1 for both.
- **Straddle.** mem[0]=0x00930001, mem[4]=0x00010010 → 0x00000001 @0 (c=1), then 0x00100093 @2 (c=0), then 0x00000001 @6.
- **Redirect with stale data.** 2 outstanding requests, `redirect_en`=1, `redirect_addr`=0x102 → both old responses dropped; request 0x100 issued next cycle; first `ins_pc`=0x102 taken from the high halfword of mem[0x100].
- **Backpressure.** `ins_ready`=0 for 6 cycles → `ins_*` constant; `imem_req_valid` falls once the buffer reservation is full; no data is lost after `ins_ready` returns to 1.
- **`IFETCH_RVC_EN` undefined.** mem[0]=0x45010505 → single instruction 0x45010505 @0, `ins_c`=0, next pc 4.

Source files
------------

// File: rtl/ifetch_align.sv
// Instruction fetch/realign: word reads into a halfword buffer, one aligned instruction per handshake to decode.
// Define IFETCH_RVC_EN for 16-bit RVC realignment; without it every instruction is a whole 32-bit word.
module ifetch_align #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          BUF_HW   = 6,
  parameter int          MAX_OUT  = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        redirect_en,
  input  logic [31:0] redirect_addr,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_data,
  output logic [31:0] ins_pc,
  output logic        ins_c
);

`ifdef IFETCH_RVC_EN
  localparam bit          RVC_EN  = 1'b1;
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFE;
`else
  localparam bit          RVC_EN  = 1'b0;
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;
`endif
  localparam int CW = $clog2(BUF_HW + 1);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int AW = $clog2(BUF_HW);

  logic [31:0]   pc_q, pc_n;
  logic [31:0]   fetch_q, fetch_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [OW-1:0] live_q, live_n;
  logic [OW-1:0] stale_q, stale_n;
  logic          drop_hw_q, drop_n;
  logic [15:0]   hw_buf_q [BUF_HW];
  logic [15:0]   hw_buf_n [BUF_HW];
  logic          is_c, req_fire, ins_fire, keep_rsp;
  int            room, pop, fill, live_i, stale_i;
  logic          unused_ok;

  assign unused_ok = ^{drop_n, redirect_addr[1:0]};

  assign is_c      = RVC_EN && (hw_buf_q[0][1:0] != 2'b11);
  assign ins_valid = is_c ? (cnt_q != '0) : (cnt_q >= CW'(2));
  assign ins_c     = ins_valid && is_c;
  assign ins_pc    = pc_q;
  assign ins_data  = !ins_valid ? 32'h0 :
                     is_c       ? {16'h0, hw_buf_q[0]} : {hw_buf_q[1], hw_buf_q[0]};

  // Each live request reserves two buffer slots so a response can always be pushed.
  always_comb begin
    room           = BUF_HW - int'(cnt_q) - 2 * int'(live_q);
    imem_req_valid = !redirect_en && (int'(live_q) + int'(stale_q) < MAX_OUT) && (room >= 2);
  end

  assign imem_req_addr = fetch_q;
  assign req_fire      = imem_req_valid && imem_req_ready;
  assign ins_fire      = ins_valid && ins_ready && !redirect_en;

  always_comb begin
    pc_n     = pc_q;
    fetch_n  = fetch_q;
    cnt_n    = cnt_q;
    live_n   = live_q;
    stale_n  = stale_q;
    drop_n   = drop_hw_q;
    hw_buf_n = hw_buf_q;
    pop      = 0;
    fill     = 0;
    live_i   = 0;
    stale_i  = 0;
    keep_rsp = 1'b0;
    if (redirect_en) begin
      // Everything in flight becomes stale; a response landing this cycle retires one of them.
      pc_n    = redirect_addr & PC_MASK;
      fetch_n = {redirect_addr[31:2], 2'b00};
      drop_n  = RVC_EN && redirect_addr[1];
      stale_i = int'(stale_q) + int'(live_q) - (imem_rsp_valid ? 1 : 0);
      stale_n = OW'(stale_i);
      live_n  = '0;
      cnt_n   = '0;
    end else begin
      if (req_fire) fetch_n = fetch_q + 32'd4;
      if (ins_fire) begin
        pop  = is_c ? 1 : 2;
        pc_n = pc_q + (is_c ? 32'd2 : 32'd4);
      end
      live_i  = int'(live_q) + (req_fire ? 1 : 0);
      stale_i = int'(stale_q);
      if (imem_rsp_valid) begin
        if (stale_q != '0) begin
          stale_i = stale_i - 1;
        end else begin
          live_i   = live_i - 1;
          keep_rsp = 1'b1;
        end
      end
      fill = int'(cnt_q) - pop;
      for (int i = 0; i < BUF_HW; i++) begin
        if (i + pop < BUF_HW) hw_buf_n[i] = hw_buf_q[AW'(i + pop)];
        else                  hw_buf_n[i] = '0;
        if (keep_rsp) begin
          if (drop_hw_q) begin
            if (i == fill) hw_buf_n[i] = imem_rsp_data[31:16];
          end else begin
            if (i == fill)     hw_buf_n[i] = imem_rsp_data[15:0];
            if (i == fill + 1) hw_buf_n[i] = imem_rsp_data[31:16];
          end
        end
      end
      if (keep_rsp) begin
        fill   = fill + (drop_hw_q ? 1 : 2);
        drop_n = 1'b0;
      end
      cnt_n   = CW'(fill);
      live_n  = OW'(live_i);
      stale_n = OW'(stale_i);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q    <= RESET_PC & PC_MASK;
      fetch_q <= {RESET_PC[31:2], 2'b00};
      cnt_q   <= '0;
      live_q  <= '0;
      stale_q <= '0;
      for (int i = 0; i < BUF_HW; i++) hw_buf_q[i] <= '0;
    end else begin
      pc_q     <= pc_n;
      fetch_q  <= fetch_n;
      cnt_q    <= cnt_n;
      live_q   <= live_n;
      stale_q  <= stale_n;
      hw_buf_q <= hw_buf_n;
    end
  end

`ifdef IFETCH_RVC_EN
  // Entering at an odd halfword: the low half of the first word belongs to the previous instruction.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) drop_hw_q <= RESET_PC[1];
    else       drop_hw_q <= drop_n;
  end
`else
  assign drop_hw_q = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_align.sv
// Bench for ifetch_align: memory model with configurable latency and a queue of expected
// instructions produced by a reference decode of memory contents.
module tb_ifetch_align;
  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_addr = 32'h0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        ins_valid;
  logic        ins_ready = 1'b1;
  logic [31:0] ins_data;
  logic [31:0] ins_pc;
  logic        ins_c;

  typedef struct { logic [31:0] pc; logic [31:0] data; logic c; } ins_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  ins_t        exp_q[$];
  mreq_t       mq[$];
  logic [31:0] mem [256];
  int          mem_lat = 1;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  ifetch_align dut (
    .clk(clk), .rstn(rstn),
    .redirect_en(redirect_en), .redirect_addr(redirect_addr),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_data(ins_data),
    .ins_pc(ins_pc), .ins_c(ins_c)
  );

  always #5 clk = ~clk;

  // In-order memory: request seen in cycle N answers during cycle N+mem_lat.
  always begin
    mreq_t r;
    @(negedge clk);
    if (!rstn) begin
      mq.delete();
    end else if (imem_req_valid && imem_req_ready) begin
      r.addr = imem_req_addr;
      r.due  = cyc + mem_lat;
      mq.push_back(r);
    end
    @(posedge clk);
    #1;
    cyc++;
    imem_rsp_valid = 1'b0;
    if (rstn && mq.size() > 0 && mq[0].due <= cyc) begin
      r = mq.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem[r.addr[9:2]];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
  endtask

  // Reference decode: walk memory from start and queue the instructions decode should see.
  task automatic push_stream(input logic [31:0] start, input int n);
    logic [31:0] p;
    ins_t        e;
`ifdef IFETCH_RVC_EN
    logic [15:0] h;
    p = {start[31:1], 1'b0};
`else
    p = {start[31:2], 2'b00};
`endif
    for (int k = 0; k < n; k++) begin
      e.pc = p;
`ifdef IFETCH_RVC_EN
      h = hw_at(p);
      if (h[1:0] != 2'b11) begin
        e.data = {16'h0, h};
        e.c    = 1'b1;
        p      = p + 32'd2;
      end else begin
        e.data = {hw_at(p + 32'd2), h};
        e.c    = 1'b0;
        p      = p + 32'd4;
      end
`else
      e.data = mem[p[9:2]];
      e.c    = 1'b0;
      p      = p + 32'd4;
`endif
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset(input int lat);
    rstn           = 1'b0;
    redirect_en    = 1'b0;
    redirect_addr  = 32'h0;
    ins_ready      = 1'b1;
    imem_req_ready = 1'b1;
    mem_lat        = lat;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_reset();
    fill_mem();
    mem_lat = 1;
    ins_ready = 1'b1;
    #2 rstn = 1'b0;
    @(negedge clk);
    checks++;
    if ({ins_valid, ins_c} !== 2'b00) begin
      errors++; $display("FAIL reset_valid_c: got valid=%b c=%b, expected 0 0", ins_valid, ins_c);
    end
    checks++;
    if (ins_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h, expected 00000000", ins_pc); end
    checks++;
    if (ins_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h, expected 00000000", ins_data); end
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      errors++; $display("FAIL reset_req: got valid=%b addr=%h, expected 1 00000000", imem_req_valid, imem_req_addr);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || ins_valid !== 1'b0) begin
      errors++; $display("FAIL first_req: got req=%b addr=%h ins_valid=%b, expected 1 00000000 0",
                         imem_req_valid, imem_req_addr, ins_valid);
    end
    @(negedge clk);
    checks++;
    if (ins_valid !== 1'b0) begin errors++; $display("FAIL cycle1_valid: got %b, expected 0", ins_valid); end
    @(negedge clk);
    checks++;
    if (ins_valid !== 1'b1 || ins_pc !== 32'h0 || ins_data !== 32'h0000_0013 || ins_c !== 1'b0) begin
      errors++; $display("FAIL cycle2_ins: got v=%b pc=%h data=%h c=%b, expected 1 00000000 00000013 0",
                         ins_valid, ins_pc, ins_data, ins_c);
    end
    @(negedge clk);
    checks++;
    if (ins_valid !== 1'b1 || ins_pc !== 32'h4) begin
      errors++; $display("FAIL second_pc: got v=%b pc=%h, expected 1 00000004", ins_valid, ins_pc);
    end
  endtask

  task automatic test_rvc_pair();
    ins_t e;
    fill_mem();
    mem[0] = 32'h4501_0505;
    do_reset(1);
    push_stream(32'h0, 3);
    for (int cy = 0; cy < 300 && exp_q.size() > 0; cy++) begin
      @(negedge clk);
      if (ins_valid && ins_ready && !redirect_en) begin
        e = exp_q.pop_front();
        checks++;
        if (ins_pc !== e.pc || ins_data !== e.data || ins_c !== e.c) begin
          errors++; $display("FAIL rvc_pair: got pc=%h data=%h c=%b, expected pc=%h data=%h c=%b",
                             ins_pc, ins_data, ins_c, e.pc, e.data, e.c);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rvc_pair_drain: %0d instructions missing, expected 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_straddle();
    ins_t e;
    fill_mem();
    mem[0] = 32'h0093_0001;
    mem[1] = 32'h0001_0010;
    do_reset(1);
    push_stream(32'h0, 5);
    for (int cy = 0; cy < 300 && exp_q.size() > 0; cy++) begin
      @(negedge clk);
      if (ins_valid && ins_ready && !redirect_en) begin
        e = exp_q.pop_front();
        checks++;
        if (ins_pc !== e.pc || ins_data !== e.data || ins_c !== e.c) begin
          errors++; $display("FAIL straddle: got pc=%h data=%h c=%b, expected pc=%h data=%h c=%b",
                             ins_pc, ins_data, ins_c, e.pc, e.data, e.c);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL straddle_drain: %0d instructions missing, expected 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_backpressure();
    ins_t e;
    fill_mem();
    for (int i = 0; i < 16; i++) mem[i] = $urandom();
    do_reset(1);
    ins_ready = 1'b0;
    push_stream(32'h0, 20);
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (ins_valid) break;
    end
    for (int s = 0; s < 6; s++) begin
      if (s > 0) @(negedge clk);
      checks++;
      if (ins_valid !== 1'b1 || ins_pc !== exp_q[0].pc || ins_data !== exp_q[0].data || ins_c !== exp_q[0].c) begin
        errors++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h data=%h c=%b, expected 1 pc=%h data=%h c=%b",
                           s, ins_valid, ins_pc, ins_data, ins_c, exp_q[0].pc, exp_q[0].data, exp_q[0].c);
      end
    end
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL stall_req: got imem_req_valid=%b with full buffer, expected 0", imem_req_valid);
    end
    @(posedge clk);
    #1 ins_ready = 1'b1;
    for (int cy = 0; cy < 300 && exp_q.size() > 0; cy++) begin
      @(negedge clk);
      if (ins_valid && ins_ready && !redirect_en) begin
        e = exp_q.pop_front();
        checks++;
        if (ins_pc !== e.pc || ins_data !== e.data || ins_c !== e.c) begin
          errors++; $display("FAIL backpressure: got pc=%h data=%h c=%b, expected pc=%h data=%h c=%b",
                             ins_pc, ins_data, ins_c, e.pc, e.data, e.c);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL backpressure_drain: %0d instructions missing, expected 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_redirect();
    ins_t e;
    fill_mem();
    mem[0]    = 32'hdead_beef;
    mem[1]    = 32'h1234_5678;
    mem[8'h40] = 32'h4581_0013;
    mem[8'h41] = 32'h0093_4505;
    do_reset(2);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 redirect_en = 1'b1;
    redirect_addr = 32'h0000_0102;
    push_stream(32'h0000_0102, 6);
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL redirect_noreq: got imem_req_valid=%b in redirect cycle, expected 0", imem_req_valid);
    end
    @(posedge clk);
    #1 redirect_en = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0100) begin
      errors++; $display("FAIL redirect_req: got valid=%b addr=%h, expected 1 00000100", imem_req_valid, imem_req_addr);
    end
    for (int cy = 0; cy < 300 && exp_q.size() > 0; cy++) begin
      @(negedge clk);
      if (ins_valid && ins_ready && !redirect_en) begin
        e = exp_q.pop_front();
        checks++;
        if (ins_pc !== e.pc || ins_data !== e.data || ins_c !== e.c) begin
          errors++; $display("FAIL redirect: got pc=%h data=%h c=%b, expected pc=%h data=%h c=%b",
                             ins_pc, ins_data, ins_c, e.pc, e.data, e.c);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL redirect_drain: %0d instructions missing, expected 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_redirect_stall();
    ins_t e;
    fill_mem();
    mem[8'h7F] = 32'h0001_0000;
    mem[8'h80] = 32'h4501_0513;
    do_reset(1);
    ins_ready = 1'b0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (ins_valid) break;
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 redirect_en = 1'b1;
    redirect_addr = 32'h0000_01FE;
    @(posedge clk);
    #1 redirect_en = 1'b0;
    @(negedge clk);
    checks++;
    if (ins_valid !== 1'b0) begin
      errors++; $display("FAIL redirect_flush: got ins_valid=%b after redirect, expected 0", ins_valid);
    end
    push_stream(32'h0000_01FE, 4);
    ins_ready = 1'b1;
    for (int cy = 0; cy < 300 && exp_q.size() > 0; cy++) begin
      @(negedge clk);
      if (ins_valid && ins_ready && !redirect_en) begin
        e = exp_q.pop_front();
        checks++;
        if (ins_pc !== e.pc || ins_data !== e.data || ins_c !== e.c) begin
          errors++; $display("FAIL redirect_stall: got pc=%h data=%h c=%b, expected pc=%h data=%h c=%b",
                             ins_pc, ins_data, ins_c, e.pc, e.data, e.c);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL redirect_stall_drain: %0d instructions missing, expected 0", exp_q.size()); exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_rvc_pair();
    test_straddle();
    test_backpressure();
    test_redirect();
    test_redirect_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
